// File: rtl/dt_ridge_extract.sv
// Ridge extractor: raster-scans the finished distance map, marks nonzero pixels that are
// >= all 4-neighbours and packs them MSB-first into skeleton words. DIAG_NEIGH_EN adds the diagonals.
module dt_ridge_extract #(
  parameter int unsigned IMG_LOG2 = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  res_rd_o,
  output logic [2*IMG_LOG2-1:0] res_addr_o,
  input  logic [7:0]            res_di_i,
  output logic                  skel_wr_o,
  output logic [2*IMG_LOG2-5:0] skel_addr_o,
  output logic [15:0]           skel_do_o,
  output logic [2*IMG_LOG2:0]   ridge_cnt_o,
  output logic [7:0]            max_dist_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned RW = IMG_LOG2;
  localparam int unsigned AW = 2 * IMG_LOG2;
  localparam int unsigned SW = AW - 4;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 8;
  localparam int unsigned WW = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_C, S_N0, S_N1, S_N2, S_N3, S_N4, S_N5, S_N6, S_N7, S_EVAL, S_WR, S_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d, col_q, col_d;
  logic [DW-1:0]   centre_q, centre_d, nmax_q, nmax_d;
  logic [WW-2:0]   shift_q, shift_d;
  logic            rd_dly_q;
  logic            res_rd_q, res_rd_d;
  logic [AW-1:0]   res_addr_q, res_addr_d;
  logic            skel_wr_q, skel_wr_d;
  logic [SW-1:0]   skel_addr_q, skel_addr_d;
  logic [WW-1:0]   skel_do_q, skel_do_d;
  logic [CW-1:0]   ridge_cnt_q, ridge_cnt_d;
  logic [DW-1:0]   max_dist_q, max_dist_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            row_top, row_bot, col_lft, col_rgt;
  logic [RW-1:0]   row_up, row_dn, col_l, col_r;
  logic [AW-1:0]   pix_addr, pix_nxt;
  logic [DW-1:0]   cand, nmax_all;
  logic            ridge_bit;
  logic [WW-1:0]   word_nxt;
  logic            iss_en, iss_vld;
  logic [AW-1:0]   iss_addr;

  // Image-edge flags and neighbour coordinates of the current pixel
  assign row_top  = (row_q == '0);
  assign row_bot  = (row_q == '1);
  assign col_lft  = (col_q == '0);
  assign col_rgt  = (col_q == '1);
  assign row_up   = row_q - RW'(1);
  assign row_dn   = row_q + RW'(1);
  assign col_l    = col_q - RW'(1);
  assign col_r    = col_q + RW'(1);
  assign pix_addr = {row_q, col_q};
  assign pix_nxt  = pix_addr + AW'(1);

  // Read data counts only if a real read was issued last cycle; skipped reads act as 0
  assign cand      = rd_dly_q ? res_di_i : '0;
  assign nmax_all  = (cand > nmax_q) ? cand : nmax_q;
  assign ridge_bit = (centre_q != '0) && (centre_q >= nmax_all);
  assign word_nxt  = {shift_q, ridge_bit};

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    centre_d    = centre_q;
    nmax_d      = nmax_q;
    shift_d     = shift_q;
    res_rd_d    = 1'b0;
    res_addr_d  = res_addr_q;
    skel_wr_d   = 1'b0;
    skel_addr_d = skel_addr_q;
    skel_do_d   = skel_do_q;
    ridge_cnt_d = ridge_cnt_q;
    max_dist_d  = max_dist_q;
    busy_d      = busy_q;
    done_d      = done_q;
    iss_en      = 1'b0;
    iss_vld     = 1'b0;
    iss_addr    = res_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          row_d       = '0;
          col_d       = '0;
          shift_d     = '0;
          ridge_cnt_d = '0;
          max_dist_d  = '0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          res_rd_d    = 1'b1;
          res_addr_d  = '0;
          state_d     = S_C;
        end
      end
      S_C: begin
        iss_en   = 1'b1;
        iss_vld  = !row_top;
        iss_addr = {row_up, col_q};
        state_d  = S_N0;
      end
      S_N0: begin
        centre_d = res_di_i;
        nmax_d   = '0;
        if (res_di_i == '0) begin
          state_d = S_EVAL;
        end else begin
          iss_en   = 1'b1;
          iss_vld  = !col_lft;
          iss_addr = {row_q, col_l};
          state_d  = S_N1;
        end
      end
      S_N1: begin
        nmax_d   = nmax_all;
        iss_en   = 1'b1;
        iss_vld  = !col_rgt;
        iss_addr = {row_q, col_r};
        state_d  = S_N2;
      end
      S_N2: begin
        nmax_d   = nmax_all;
        iss_en   = 1'b1;
        iss_vld  = !row_bot;
        iss_addr = {row_dn, col_q};
        state_d  = S_N3;
      end
      S_N3: begin
        nmax_d = nmax_all;
`ifdef DIAG_NEIGH_EN
        iss_en   = 1'b1;
        iss_vld  = !row_top && !col_lft;
        iss_addr = {row_up, col_l};
        state_d  = S_N4;
`else
        state_d = S_EVAL;
`endif
      end
`ifdef DIAG_NEIGH_EN
      S_N4: begin
        nmax_d   = nmax_all;
        iss_en   = 1'b1;
        iss_vld  = !row_top && !col_rgt;
        iss_addr = {row_up, col_r};
        state_d  = S_N5;
      end
      S_N5: begin
        nmax_d   = nmax_all;
        iss_en   = 1'b1;
        iss_vld  = !row_bot && !col_lft;
        iss_addr = {row_dn, col_l};
        state_d  = S_N6;
      end
      S_N6: begin
        nmax_d   = nmax_all;
        iss_en   = 1'b1;
        iss_vld  = !row_bot && !col_rgt;
        iss_addr = {row_dn, col_r};
        state_d  = S_N7;
      end
      S_N7: begin
        nmax_d  = nmax_all;
        state_d = S_EVAL;
      end
`endif
      S_EVAL: begin
        shift_d     = word_nxt[WW-2:0];
        ridge_cnt_d = ridge_cnt_q + CW'(ridge_bit);
        max_dist_d  = (centre_q > max_dist_q) ? centre_q : max_dist_q;
        if (col_q[3:0] == 4'hF) begin
          skel_wr_d   = 1'b1;
          skel_addr_d = pix_addr[AW-1:4];
          skel_do_d   = word_nxt;
          state_d     = S_WR;
        end else begin
          {row_d, col_d} = pix_nxt;
          res_rd_d       = 1'b1;
          res_addr_d     = pix_nxt;
          state_d        = S_C;
        end
      end
      S_WR: begin
        if (&pix_addr) begin
          state_d = S_FIN;
        end else begin
          {row_d, col_d} = pix_nxt;
          res_rd_d       = 1'b1;
          res_addr_d     = pix_nxt;
          state_d        = S_C;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Out-of-image neighbours suppress the read and leave the address untouched
    if (iss_en) begin
      res_rd_d = iss_vld;
      if (iss_vld) res_addr_d = iss_addr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      centre_q    <= '0;
      nmax_q      <= '0;
      shift_q     <= '0;
      rd_dly_q    <= 1'b0;
      res_rd_q    <= 1'b0;
      res_addr_q  <= '0;
      skel_wr_q   <= 1'b0;
      skel_addr_q <= '0;
      skel_do_q   <= '0;
      ridge_cnt_q <= '0;
      max_dist_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      centre_q    <= centre_d;
      nmax_q      <= nmax_d;
      shift_q     <= shift_d;
      rd_dly_q    <= res_rd_q;
      res_rd_q    <= res_rd_d;
      res_addr_q  <= res_addr_d;
      skel_wr_q   <= skel_wr_d;
      skel_addr_q <= skel_addr_d;
      skel_do_q   <= skel_do_d;
      ridge_cnt_q <= ridge_cnt_d;
      max_dist_q  <= max_dist_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign res_rd_o    = res_rd_q;
  assign res_addr_o  = res_addr_q;
  assign skel_wr_o   = skel_wr_q;
  assign skel_addr_o = skel_addr_q;
  assign skel_do_o   = skel_do_q;
  assign ridge_cnt_o = ridge_cnt_q;
  assign max_dist_o  = max_dist_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_dt_ridge_extract.sv
// Directed bench for dt_ridge_extract on a 32x32 image so every scenario fits a short run.
// Honours DIAG_NEIGH_EN for the 8-neighbour expectations.
module tb_dt_ridge_extract;

  localparam int IMG_LOG2 = 5;
  localparam int SIDE     = 1 << IMG_LOG2;
  localparam int NPIX     = SIDE * SIDE;
  localparam int NWORD    = NPIX / 16;
  localparam int AW       = 2 * IMG_LOG2;
  localparam int SW       = AW - 4;
  localparam int CW       = AW + 1;
  localparam int OW       = 1 + AW + 1 + SW + 16 + CW + 8 + 1 + 1;
  localparam int BASE_CYC = 3 * NPIX + NWORD + 2;
`ifdef DIAG_NEIGH_EN
  localparam int NZ_EXTRA = 7;
`else
  localparam int NZ_EXTRA = 3;
`endif
  localparam int BUDGET   = 20000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          res_rd;
  logic [AW-1:0] res_addr;
  logic [7:0]    res_di;
  logic          skel_wr;
  logic [SW-1:0] skel_addr;
  logic [15:0]   skel_do;
  logic [CW-1:0] ridge_cnt;
  logic [7:0]    max_dist;
  logic          busy;
  logic          done;
  logic [OW-1:0] all_outs;

  logic [7:0]    mem  [NPIX];
  logic [15:0]   skel [NWORD];
  int            n_cmp = 0;
  int            n_err = 0;
  int            wr_cnt;
  int            busy_bad;
  int            cyc;
  bit            found;

  dt_ridge_extract #(.IMG_LOG2(IMG_LOG2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .res_rd_o   (res_rd),
    .res_addr_o (res_addr),
    .res_di_i   (res_di),
    .skel_wr_o  (skel_wr),
    .skel_addr_o(skel_addr),
    .skel_do_o  (skel_do),
    .ridge_cnt_o(ridge_cnt),
    .max_dist_o (max_dist),
    .busy_o     (busy),
    .done_o     (done)
  );

  assign all_outs = {res_rd, res_addr, skel_wr, skel_addr, skel_do, ridge_cnt, max_dist, busy, done};

  always #5 clk = ~clk;

  // Synchronous-read res RAM
  always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
  endtask

  task automatic set_px(input int r, input int c, input logic [7:0] v);
    mem[r * SIDE + c] = v;
  endtask

  function automatic int count_nz();
    int n = 0;
    for (int i = 0; i < NWORD; i++) if (skel[i] != 16'h0000) n++;
    return n;
  endfunction

  // Start a scan, capture skeleton writes, optionally re-pulse start at cycle pulse_at
  task automatic run_scan(input int pulse_at, output int cycles);
    for (int i = 0; i < NWORD; i++) skel[i] = 16'hDEAD;
    wr_cnt   = 0;
    busy_bad = 0;
    start    = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    check_eq("first_read", 64'({res_rd, res_addr}), 64'({1'b1, AW'(0)}));
    while (!done && cycles < BUDGET) begin
      if (!busy) busy_bad++;
      if (skel_wr) begin
        skel[skel_addr] = skel_do;
        wr_cnt++;
      end
      @(posedge clk); #1;
      cycles++;
      start = (pulse_at > 0 && cycles == pulse_at);
    end
    start = 1'b0;
    check_eq("busy_during_scan", 64'(busy_bad), 64'd0);
    check_eq("word_writes", 64'(wr_cnt), 64'(NWORD));
    @(posedge clk); #1;
    check_eq("idle_after_done", 64'({busy, done}), 64'b01);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_map();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outs", 64'(all_outs), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_outs", 64'(all_outs), 64'd0);

    // All-zero map
    run_scan(0, cyc);
    check_eq("t1_cycles", 64'(cyc), 64'(BASE_CYC));
    check_eq("t1_nz_words", 64'(count_nz()), 64'd0);
    check_eq("t1_ridge_cnt", 64'(ridge_cnt), 64'd0);
    check_eq("t1_max_dist", 64'(max_dist), 64'd0);

    // Single pixel of value 1 at (5,20)
    clear_map();
    set_px(5, 20, 8'd1);
    run_scan(0, cyc);
    check_eq("t2_cycles", 64'(cyc), 64'(BASE_CYC + NZ_EXTRA));
    check_eq("t2_word11", 64'(skel[11]), 64'h0800);
    check_eq("t2_nz_words", 64'(count_nz()), 64'd1);
    check_eq("t2_ridge_cnt", 64'(ridge_cnt), 64'd1);
    check_eq("t2_max_dist", 64'(max_dist), 64'd1);

    // Full-width bar on row 10: ties count as ridge, edges see 0 outside
    clear_map();
    for (int c = 0; c < SIDE; c++) set_px(10, c, 8'd1);
    run_scan(0, cyc);
    check_eq("t3_cycles", 64'(cyc), 64'(BASE_CYC + SIDE * NZ_EXTRA));
    check_eq("t3_word20", 64'(skel[20]), 64'hFFFF);
    check_eq("t3_word21", 64'(skel[21]), 64'hFFFF);
    check_eq("t3_nz_words", 64'(count_nz()), 64'd2);
    check_eq("t3_ridge_cnt", 64'(ridge_cnt), 64'(SIDE));
    check_eq("t3_max_dist", 64'(max_dist), 64'd1);

    // 3x3 block centred at (16,16): centre 2, ring 1
    clear_map();
    for (int r = 15; r <= 17; r++)
      for (int c = 15; c <= 17; c++) set_px(r, c, 8'd1);
    set_px(16, 16, 8'd2);
    run_scan(0, cyc);
    check_eq("t4_cycles", 64'(cyc), 64'(BASE_CYC + 9 * NZ_EXTRA));
    check_eq("t4_word33", 64'(skel[33]), 64'h8000);
    check_eq("t4_max_dist", 64'(max_dist), 64'd2);
`ifdef DIAG_NEIGH_EN
    check_eq("t4_nz_words", 64'(count_nz()), 64'd1);
    check_eq("t4_ridge_cnt", 64'(ridge_cnt), 64'd1);
`else
    check_eq("t4_word30", 64'(skel[30]), 64'h0001);
    check_eq("t4_word31", 64'(skel[31]), 64'h4000);
    check_eq("t4_word34", 64'(skel[34]), 64'h0001);
    check_eq("t4_word35", 64'(skel[35]), 64'h4000);
    check_eq("t4_nz_words", 64'(count_nz()), 64'd5);
    check_eq("t4_ridge_cnt", 64'(ridge_cnt), 64'd5);
`endif

    // Second start mid-scan must not restart or stretch the scan
    clear_map();
    set_px(5, 20, 8'd1);
    run_scan(500, cyc);
    check_eq("t5_cycles", 64'(cyc), 64'(BASE_CYC + NZ_EXTRA));
    check_eq("t5_word11", 64'(skel[11]), 64'h0800);
    check_eq("t5_nz_words", 64'(count_nz()), 64'd1);
    check_eq("t5_ridge_cnt", 64'(ridge_cnt), 64'd1);

    // Reset while the centre read of pixel 300 is on the bus, then full rescan
    clear_map();
    for (int r = 15; r <= 17; r++)
      for (int c = 15; c <= 17; c++) set_px(r, c, 8'd1);
    set_px(16, 16, 8'd2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < BUDGET && !found; c++) begin
      if (res_rd && res_addr == AW'(300)) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check_eq("t6_reach_pix300", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_reset_outs", 64'(all_outs), 64'd0);
    wr_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (skel_wr) wr_cnt++;
    end
    check_eq("t6_no_wr_in_reset", 64'(wr_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_idle_outs", 64'(all_outs), 64'd0);
    run_scan(0, cyc);
    check_eq("t6_cycles", 64'(cyc), 64'(BASE_CYC + 9 * NZ_EXTRA));
    check_eq("t6_word33", 64'(skel[33]), 64'h8000);
`ifdef DIAG_NEIGH_EN
    check_eq("t6_ridge_cnt", 64'(ridge_cnt), 64'd1);
`else
    check_eq("t6_ridge_cnt", 64'(ridge_cnt), 64'd5);
`endif
    check_eq("t6_max_dist", 64'(max_dist), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
